present_mode_ctrl: RTL

- Mode controller that sits directly upstream of the PRESENT core. It feeds the core's block, key, enc_dec and rst inputs, and consumes its block_o and end_signal outputs.
- Accepts 64-bit blocks over a valid/ready stream and runs one core operation per block.
- Supports ECB or CBC chaining, with a per-block cycle counter for performance measurement.
- Lets the autotest harness stream multi-block messages without sequencing the core by hand.

---
 rtl/present_pkg.sv | 18 +
 rtl/present_mode_ctrl_if.sv | 22 ++
 rtl/present_mode_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared widths, types and FSM states for the PRESENT mode controller
package present_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [KEY_W-1:0]   key_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        OUT,
        ERR
    } state_t;

endpackage

// File: rtl/present_mode_ctrl_if.sv
// rtl/present_mode_ctrl_if.sv - block input/output stream bundle between harness and mode controller
interface present_mode_ctrl_if;
    import present_pkg::*;

    logic   in_valid_i;
    logic   in_ready_o;
    block_t in_block_i;
    logic   out_valid_o;
    logic   out_ready_i;
    block_t out_block_o;

    modport master (
        output in_valid_i, in_block_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_block_o
    );

    modport slave (
        input  in_valid_i, in_block_i, out_ready_i,
        output in_ready_o, out_valid_o, out_block_o
    );

endinterface

// File: rtl/present_mode_ctrl.sv
// rtl/present_mode_ctrl.sv - ECB/CBC sequencer feeding one PRESENT core operation per streamed block
module present_mode_ctrl
    import present_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cbc_i,
    input  logic               enc_dec_i,
    input  key_t               key_i,
    input  block_t             iv_i,
    input  logic               iv_load_i,
    present_mode_ctrl_if.slave stream,
    output logic               busy_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   cycles_o,
    output logic               core_rst_o,
    output logic               core_enc_dec_o,
    output key_t               core_key_o,
    output block_t             core_block_o,
    input  block_t             core_block_i,
    input  logic               core_end_i,
    input  logic               core_end_key_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    block_t           chain, saved_in, out_r;
    key_t             key_r;
    logic             enc_r, cbc_r;
    logic [CNT_W-1:0] cnt, cnt_inc, cycles_r;

    // End-of-key-schedule strobe is only of interest to the harness.
    logic unused_end_key;
    assign unused_end_key = core_end_key_i;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    assign core_block_o       = saved_in ^ ((cbc_r && enc_r) ? chain : '0);
    assign core_key_o         = key_r;
    assign core_enc_dec_o     = enc_r;
    assign cycles_o           = cycles_r;
    assign stream.out_block_o = out_r;

    always_comb begin
        state_nxt          = state;
        stream.in_ready_o  = 1'b0;
        stream.out_valid_o = 1'b0;
        core_rst_o         = 1'b1;
        busy_o             = 1'b1;
        timeout_o          = 1'b0;
        case (state)
            IDLE: begin
                stream.in_ready_o = 1'b1;
                busy_o            = 1'b0;
                if (stream.in_valid_i) state_nxt = START;
            end
            START: state_nxt = RUN;
            RUN: begin
                core_rst_o = 1'b0;
                if (core_end_i)           state_nxt = OUT;
                else if (cnt == CNT_LAST) state_nxt = ERR;
            end
            OUT: begin
                stream.out_valid_o = 1'b1;
                if (stream.out_ready_i) state_nxt = IDLE;
            end
            ERR:     timeout_o = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            chain    <= '0;
            saved_in <= '0;
            out_r    <= '0;
            key_r    <= '0;
            enc_r    <= 1'b0;
            cbc_r    <= 1'b0;
            cnt      <= '0;
            cycles_r <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (iv_load_i) chain <= iv_i;
                    if (stream.in_valid_i) begin
                        saved_in <= stream.in_block_i;
                        key_r    <= key_i;
                        enc_r    <= enc_dec_i;
                        cbc_r    <= cbc_i;
                    end
                end
                START: cnt <= '0;
                RUN: begin
                    cnt <= cnt_inc;
                    if (core_end_i) begin
                        cycles_r <= cnt_inc;
                        // CBC decrypt chains on the ciphertext that went in, not on the plaintext out.
                        if (enc_r) begin
                            out_r <= core_block_i;
                            if (cbc_r) chain <= core_block_i;
                        end else begin
                            out_r <= core_block_i ^ (cbc_r ? chain : '0);
                            if (cbc_r) chain <= saved_in;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
